// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame-buffer write path.
package pixel_pkg;

  localparam int COORD_W = 7;
  localparam int OFF_W   = 5;

  typedef logic [2:0] color_t;

  localparam color_t ERASE = 3'b000;
  localparam color_t RED   = 3'b100;
  localparam color_t GREEN = 3'b010;
  localparam color_t BLUE  = 3'b001;
  localparam color_t WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BRUSH = 2'd1,
    CLEAR = 2'd2
  } sched_state_t;

endpackage

// File: rtl/brush_scan.sv
// Row-major dx/dy offset walker for one BRUSH_SIZE x BRUSH_SIZE stamp.
// dx_o/dy_o give the offset of the slot to be issued at the next clock edge.
module brush_scan
  import pixel_pkg::*;
#(
  parameter int BRUSH_SIZE = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    step_i,
  output logic signed [OFF_W-1:0] dx_o,
  output logic signed [OFF_W-1:0] dy_o,
  output logic                    last_o
);

  localparam logic signed [OFF_W-1:0] POS_R = OFF_W'(BRUSH_SIZE / 2);
  localparam logic signed [OFF_W-1:0] NEG_R = -POS_R;
  localparam logic signed [OFF_W-1:0] ONE   = OFF_W'(1);

  logic signed [OFF_W-1:0] dx_q, dx_d;
  logic signed [OFF_W-1:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q + ONE;
    dy_d = dy_q;
    if (start_i) begin
      dx_d = NEG_R;
      dy_d = NEG_R;
    end else if (dx_q == POS_R) begin
      dx_d = NEG_R;
      dy_d = dy_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dx_q <= NEG_R;
      dy_q <= NEG_R;
    end else if (start_i || step_i) begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_o   = dx_d;
  assign dy_o   = dy_d;
  assign last_o = (dx_q == POS_R) && (dy_q == POS_R);

endmodule

// File: rtl/pixel_write_sched.sv
// Frame-buffer write scheduler: clipped brush stamps (one write/cycle, first write the cycle after accept)
// and, with PIXEL_CLEAR_EN defined, a full-screen clear sweep; req_ready is low while a stroke/clear runs.
module pixel_write_sched #(
  parameter int COORD_W    = pixel_pkg::COORD_W,
  parameter int BRUSH_SIZE = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [COORD_W:0]       wx_i,
  input  logic [COORD_W:0]       wy_i,
  input  logic [2:0]             new_color_i,
  input  logic                   clear_req_i,
  output logic                   wr_en_o,
  output logic [2*COORD_W-1:0]   wr_addr_o,
  output logic [2:0]             wr_color_o,
  output logic                   busy_o,
  output logic                   clear_done_o
);

  import pixel_pkg::*;

  localparam int AW = 2 * COORD_W;
  localparam int XW = COORD_W + 3;

  sched_state_t state_q, state_d;
  logic [COORD_W:0] cx_q, cx_d, cy_q, cy_d;
  color_t           col_q, col_d;
  color_t           wr_color_q, wr_color_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             ready_q, ready_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;

  logic                    scan_start, scan_step, scan_last;
  logic signed [OFF_W-1:0] scan_dx, scan_dy;
  logic [COORD_W:0]        cen_x, cen_y;
  logic signed [XW-1:0]    px, py;
  logic                    slot_in;
  logic [AW-1:0]           slot_addr;
  logic                    clr_go;

  brush_scan #(.BRUSH_SIZE(BRUSH_SIZE)) u_scan (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (scan_start),
    .step_i  (scan_step),
    .dx_o    (scan_dx),
    .dy_o    (scan_dy),
    .last_o  (scan_last)
  );

`ifdef PIXEL_CLEAR_EN
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic [AW-1:0] clr_next;

  assign clr_go   = (state_q == IDLE) && (clear_req_i || pend_q);
  assign clr_next = wr_addr_q + AW'(1);
  // Pending only latches during a stroke; clear requests in CLEAR are dropped.
  assign pend_d   = (state_q == BRUSH) && (pend_q || clear_req_i);
  assign done_d   = (state_q == CLEAR) && (clr_next == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

  assign clear_done_o = done_q;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req_i;
  assign clr_go           = 1'b0;
  assign clear_done_o     = 1'b0;
`endif

  assign scan_start = (state_q == IDLE) && !clr_go && req_valid_i && ready_q;
  assign scan_step  = (state_q == BRUSH) && !scan_last;

  // On the accept cycle the slot is built straight from the request inputs.
  assign cen_x     = scan_start ? wx_i : cx_q;
  assign cen_y     = scan_start ? wy_i : cy_q;
  assign px        = $signed(XW'(cen_x)) + XW'(scan_dx);
  assign py        = $signed(XW'(cen_y)) + XW'(scan_dy);
  assign slot_in   = (px[XW-1:COORD_W] == '0) && (py[XW-1:COORD_W] == '0);
  assign slot_addr = {py[COORD_W-1:0], px[COORD_W-1:0]};

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    col_d      = col_q;
    ready_d    = ready_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_color_d = wr_color_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (clr_go) begin
          state_d    = CLEAR;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_color_d = ERASE;
        end else if (scan_start) begin
          state_d    = BRUSH;
          cx_d       = wx_i;
          cy_d       = wy_i;
          col_d      = new_color_i;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          wr_en_d    = slot_in;
          wr_addr_d  = slot_addr;
          wr_color_d = new_color_i;
        end
      end
      BRUSH: begin
        if (scan_last) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          wr_en_d = 1'b0;
        end else begin
          wr_en_d    = slot_in;
          wr_addr_d  = slot_addr;
          wr_color_d = col_q;
        end
      end
`ifdef PIXEL_CLEAR_EN
      CLEAR: begin
        wr_addr_d = clr_next;
        if (done_d) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          wr_en_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      col_q      <= ERASE;
      ready_q    <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_color_q <= ERASE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      col_q      <= col_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_color_q <= wr_color_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready_o = ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_color_o  = wr_color_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pixel_write_sched.sv
// Directed bench for pixel_write_sched; clear scenarios run when PIXEL_CLEAR_EN is defined.
module tb_pixel_write_sched;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        clear_req = 1'b0;
  logic [7:0]  wx = '0;
  logic [7:0]  wy = '0;
  logic [2:0]  new_color = '0;
  logic        req_ready, wr_en, busy, clear_done;
  logic [13:0] wr_addr;
  logic [2:0]  wr_color;

  int checks = 0;
  int errors = 0;

  logic       cap_en   [0:31];
  int         cap_addr [0:31];
  logic [2:0] cap_col  [0:31];
  logic       cap_rdy  [0:31];
  logic       cap_busy [0:31];
  logic       cap_done [0:31];

  always #5 clk = ~clk;

  pixel_write_sched #(.COORD_W(7), .BRUSH_SIZE(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .wx_i         (wx),
    .wy_i         (wy),
    .new_color_i  (new_color),
    .clear_req_i  (clear_req),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_color_o   (wr_color),
    .busy_o       (busy),
    .clear_done_o (clear_done)
  );

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_en[i]   = wr_en;
      cap_addr[i] = int'(wr_addr);
      cap_col[i]  = wr_color;
      cap_rdy[i]  = req_ready;
      cap_busy[i] = busy;
      cap_done[i] = clear_done;
      @(negedge clk);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge of the first write cycle.
  task automatic issue(input int x, input int y, input logic [2:0] c);
    @(negedge clk);
    wx = 8'(x); wy = 8'(y); new_color = c; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, wr_en, clear_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/en/done=%b want 1000", {req_ready, busy, wr_en, clear_done});
    end
    checks++;
    if (wr_addr !== 14'd0 || wr_color !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d col=%b want 0/000", wr_addr, wr_color);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || clear_done !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d non-idle cycles want 0", n);
    end
  endtask

  task automatic test_stroke_basic();
    int exp_a[9] = '{2441, 2442, 2443, 2569, 2570, 2571, 2697, 2698, 2699};
    int low;
    issue(10, 20, 3'b010);
    capture(10);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cap_en[i] !== 1'b1 || cap_addr[i] != exp_a[i] || cap_col[i] !== 3'b010 || cap_busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL stroke_slot%0d: got en=%b addr=%0d col=%b busy=%b want en=1 addr=%0d col=010 busy=1",
                 i, cap_en[i], cap_addr[i], cap_col[i], cap_busy[i], exp_a[i]);
      end
    end
    low = 0;
    for (int i = 0; i < 10; i++) if (cap_rdy[i] === 1'b0) low++;
    checks++;
    if (low != 9 || cap_rdy[9] !== 1'b1) begin
      errors++;
      $display("FAIL stroke_ready_low: got %0d low cycles (rdy after=%b) want 9 (1)", low, cap_rdy[9]);
    end
    checks++;
    if (cap_en[9] !== 1'b0 || cap_busy[9] !== 1'b0) begin
      errors++;
      $display("FAIL stroke_end: got en=%b busy=%b want 0/0", cap_en[9], cap_busy[9]);
    end
  endtask

  task automatic test_clip();
    int         cx[3] = '{0, 127, 200};
    int         cy[3] = '{0, 127, 5};
    logic [0:8] en[3] = '{9'b000011011, 9'b110110000, 9'b000000000};
    int         ad[3][9] = '{'{0, 0, 0, 0, 0, 1, 0, 128, 129},
                             '{16254, 16255, 0, 16382, 16383, 0, 0, 0, 0},
                             '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
    for (int k = 0; k < 3; k++) begin
      issue(cx[k], cy[k], 3'b111);
      capture(10);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cap_en[i] !== en[k][i] || (en[k][i] && cap_addr[i] != ad[k][i])) begin
          errors++;
          $display("FAIL clip_c%0d_slot%0d: got en=%b addr=%0d want en=%b addr=%0d",
                   k, i, cap_en[i], cap_addr[i], en[k][i], ad[k][i]);
        end
      end
      checks++;
      if (cap_rdy[8] !== 1'b0 || cap_rdy[9] !== 1'b1) begin
        errors++;
        $display("FAIL clip_c%0d_length: got rdy[8]=%b rdy[9]=%b want 0/1", k, cap_rdy[8], cap_rdy[9]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:8] en_b = 9'b000011011;
    int         ad_b[9] = '{0, 0, 0, 0, 0, 1, 0, 128, 129};
    @(negedge clk);
    wx = 8'd10; wy = 8'd20; new_color = 3'b101; req_valid = 1'b1;
    @(negedge clk);
    wx = 8'd0; wy = 8'd0; new_color = 3'b011;
    capture(10);
    req_valid = 1'b0;
    checks++;
    if (cap_en[0] !== 1'b1 || cap_addr[0] != 2441 || cap_en[8] !== 1'b1 || cap_addr[8] != 2699 || cap_col[0] !== 3'b101) begin
      errors++;
      $display("FAIL b2b_first: got first=%0d last=%0d col=%b want 2441/2699/101", cap_addr[0], cap_addr[8], cap_col[0]);
    end
    checks++;
    if (cap_en[9] !== 1'b0 || cap_rdy[9] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got en=%b rdy=%b want 0/1", cap_en[9], cap_rdy[9]);
    end
    capture(10);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cap_en[i] !== en_b[i] || (en_b[i] && (cap_addr[i] != ad_b[i] || cap_col[i] !== 3'b011))) begin
        errors++;
        $display("FAIL b2b_second_slot%0d: got en=%b addr=%0d col=%b want en=%b addr=%0d col=011",
                 i, cap_en[i], cap_addr[i], cap_col[i], en_b[i], ad_b[i]);
      end
    end
    checks++;
    if (cap_en[9] !== 1'b0 || cap_rdy[9] !== 1'b1 || cap_busy[9] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got en=%b rdy=%b busy=%b want 0/1/0", cap_en[9], cap_rdy[9], cap_busy[9]);
    end
  endtask

`ifdef PIXEL_CLEAR_EN
  task automatic test_clear_priority();
    int bad, first_bad, ndone;
    @(negedge clk);
    wx = 8'd10; wy = 8'd20; new_color = 3'b010; req_valid = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    bad = 0; first_bad = -1; ndone = 0;
    for (int i = 0; i < 16384; i++) begin
      if (wr_en !== 1'b1 || wr_addr !== 14'(i) || wr_color !== ERASE || req_ready !== 1'b0 || busy !== 1'b1) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      if (clear_done === 1'b1) ndone++;
      @(negedge clk);
      clear_req = (i == 100);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sweep: got %0d bad cycles (first at %0d) want 0", bad, first_bad);
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL clear_done_early: got %0d pulses during sweep want 0", ndone);
    end
    checks++;
    if (clear_done !== 1'b1 || req_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: got done/rdy/en/busy=%b want 1100", {clear_done, req_ready, wr_en, busy});
    end
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 14'd2441 || wr_color !== 3'b010 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_then_accept: got done=%b en=%b addr=%0d col=%b rdy=%b want 0/1/2441/010/0",
               clear_done, wr_en, wr_addr, wr_color, req_ready);
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_clear_mid_stroke();
    int exp_a[9] = '{2441, 2442, 2443, 2569, 2570, 2571, 2697, 2698, 2699};
    int n;
    issue(10, 20, 3'b110);
    for (int i = 0; i < 11; i++) begin
      cap_en[i] = wr_en; cap_addr[i] = int'(wr_addr); cap_col[i] = wr_color;
      cap_rdy[i] = req_ready; cap_busy[i] = busy;
      @(negedge clk);
      clear_req = (i == 2);
    end
    n = 0;
    for (int i = 0; i < 9; i++) if (cap_en[i] !== 1'b1 || cap_addr[i] != exp_a[i] || cap_col[i] !== 3'b110) n++;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midclr_stroke: got %0d bad slots want 0", n);
    end
    checks++;
    if (cap_en[9] !== 1'b0 || cap_rdy[9] !== 1'b1 || cap_busy[9] !== 1'b0) begin
      errors++;
      $display("FAIL midclr_gap: got en=%b rdy=%b busy=%b want 0/1/0", cap_en[9], cap_rdy[9], cap_busy[9]);
    end
    checks++;
    if (cap_en[10] !== 1'b1 || cap_addr[10] != 0 || cap_col[10] !== ERASE || cap_busy[10] !== 1'b1) begin
      errors++;
      $display("FAIL midclr_start: got en=%b addr=%0d col=%b busy=%b want 1/0/000/1",
               cap_en[10], cap_addr[10], cap_col[10], cap_busy[10]);
    end
    for (int k = 1; k < 500; k++) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 14'd500) begin
      errors++;
      $display("FAIL midclr_addr500: got en=%b addr=%0d want 1/500", wr_en, wr_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midclr_reset: got en=%b busy=%b rdy=%b want 0/0/1", wr_en, busy, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midclr_no_pending: got %0d active cycles after reset want 0", n);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int n;
    @(negedge clk);
    wx = 8'd10; wy = 8'd20; new_color = 3'b001; req_valid = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; clear_req = 1'b0;
    capture(10);
    checks++;
    if (cap_en[0] !== 1'b1 || cap_addr[0] != 2441 || cap_col[0] !== 3'b001) begin
      errors++;
      $display("FAIL noclr_accept: got en=%b addr=%0d col=%b want 1/2441/001", cap_en[0], cap_addr[0], cap_col[0]);
    end
    n = 0;
    for (int i = 0; i < 10; i++) if (cap_done[i] !== 1'b0) n++;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL noclr_done: got %0d clear_done cycles want 0", n);
    end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL noclr_ignored: got %0d active cycles want 0", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stroke_basic();
    test_clip();
    test_back_to_back();
`ifdef PIXEL_CLEAR_EN
    test_clear_priority();
    test_clear_mid_stroke();
`else
    test_clear_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
